memory_cycle: RTL

Memory stage of the five-stage RISC-V pipeline: consumes the EX/MEM pipeline register outputs of the execute stage and performs loads and stores over a req/ack data bus with wait states. Holds the pipeline with a stall while an access is outstanding, aborts hung accesses with a timeout counter, and drives the MEM/WB pipeline register for the write-back stage.

---
 rtl/memory_cycle_if.sv | 19 +
 rtl/memory_cycle.sv | 135 +++++++++++++
 2 files changed

// File: rtl/memory_cycle_if.sv
// rtl/memory_cycle_if.sv - req/ack data bus between the memory stage and data memory
interface memory_cycle_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/memory_cycle.sv
// rtl/memory_cycle.sv - RISC-V memory stage: bus access with stall and timeout, MEM/WB register
module memory_cycle #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                RegWriteM,
  input  logic                MemWriteM,
  input  logic                ResultSrcM,
  input  logic [4:0]          RD_M,
  input  logic [31:0]         ALU_ResultM,
  input  logic [31:0]         WriteDataM,
  input  logic [31:0]         PCPlus4M,
  memory_cycle_if.master      bus,
  output logic                StallM,
  output logic                BusErr,
  output logic                RegWriteW,
  output logic                ResultSrcW,
  output logic [4:0]          RD_W,
  output logic [31:0]         ALU_ResultW,
  output logic [31:0]         ReadDataW,
  output logic [31:0]         PCPlus4W
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        bus_err_q, bus_err_d;
  logic        reg_write_w_q, reg_write_w_d;
  logic        result_src_w_q, result_src_w_d;
  logic [4:0]  rd_w_q, rd_w_d;
  logic [31:0] alu_result_w_q, alu_result_w_d;
  logic [31:0] read_data_w_q, read_data_w_d;
  logic [31:0] pc_plus4_w_q, pc_plus4_w_d;

  logic access, is_load, ack_v, timeout, done;

  assign access  = MemWriteM | ResultSrcM;
  // A store wins when both flags are set, so only a pure load returns data.
  assign is_load = ResultSrcM & ~MemWriteM;
  assign ack_v   = bus.mem_ack & access;
  assign timeout = (state_q == S_WAIT) && (cnt_q == CNT_LAST);
  assign done    = ~access | ack_v | timeout;

  assign bus.mem_req   = rst & access;
  assign bus.mem_we    = MemWriteM;
  assign bus.mem_addr  = {ALU_ResultM[31:2], 2'b00};
  assign bus.mem_wdata = WriteDataM;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    bus_err_d      = bus_err_q;
    reg_write_w_d  = reg_write_w_q;
    result_src_w_d = result_src_w_q;
    rd_w_d         = rd_w_q;
    alu_result_w_d = alu_result_w_q;
    read_data_w_d  = read_data_w_q;
    pc_plus4_w_d   = pc_plus4_w_q;

    case (state_q)
      S_IDLE: begin
        if (access && !ack_v) begin
          state_d = S_WAIT;
          cnt_d   = 8'd1;
        end
      end
      S_WAIT: begin
        if (done) begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    if (done) begin
      reg_write_w_d  = RegWriteM;
      result_src_w_d = ResultSrcM;
      rd_w_d         = RD_M;
      alu_result_w_d = ALU_ResultM;
      pc_plus4_w_d   = PCPlus4M;
      read_data_w_d  = (is_load && ack_v) ? bus.mem_rdata : 32'd0;
      // Forced completion retires the instruction but flags the hung bus.
      if (access && !ack_v) begin
        bus_err_d = 1'b1;
      end
    end else begin
      reg_write_w_d  = 1'b0;
      result_src_w_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= 8'd0;
      bus_err_q      <= 1'b0;
      reg_write_w_q  <= 1'b0;
      result_src_w_q <= 1'b0;
      rd_w_q         <= 5'd0;
      alu_result_w_q <= 32'd0;
      read_data_w_q  <= 32'd0;
      pc_plus4_w_q   <= 32'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      bus_err_q      <= bus_err_d;
      reg_write_w_q  <= reg_write_w_d;
      result_src_w_q <= result_src_w_d;
      rd_w_q         <= rd_w_d;
      alu_result_w_q <= alu_result_w_d;
      read_data_w_q  <= read_data_w_d;
      pc_plus4_w_q   <= pc_plus4_w_d;
    end
  end

  assign StallM      = ~done;
  assign BusErr      = bus_err_q;
  assign RegWriteW   = reg_write_w_q;
  assign ResultSrcW  = result_src_w_q;
  assign RD_W        = rd_w_q;
  assign ALU_ResultW = alu_result_w_q;
  assign ReadDataW   = read_data_w_q;
  assign PCPlus4W    = pc_plus4_w_q;

endmodule
